// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter.
//   state_e : arbiter FSM states
//   grant_e : which requester owns (or last owned) the memory port
//   PH0_*   : transaction tag values seen by the memory-data demultiplexer
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitData,
    StAck,
    StWaitRelease,
    StWaitRtz
  } state_e;

  typedef enum logic {
    GntInstr,
    GntCache
  } grant_e;

  localparam logic [1:0] PH0_INSTR = 2'b10;
  localparam logic [1:0] PH0_CACHE = 2'b00;
  localparam logic [1:0] PH0_IDLE  = 2'b01;

  // Width of the WAIT_DATA timeout counter.
  localparam int unsigned TimeoutCntW = 8;

endpackage

// File: rtl/mem_port_arbiter_sync.sv
// Multi-stage flip-flop synchroniser for one asynchronous handshake bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage
//   d     : asynchronous input
//   q     : synchronised output, STAGES cycles behind d
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and data-cache requesters.
// Each winning four-phase request becomes one memory transaction tagged on ph0; the
// return-to-zero is completed on both sides before the next request is accepted.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   instr_req/instr_addr/instr_ack: fetch four-phase handshake
//   cache_req/cache_we/cache_addr/cache_wdata/cache_ack : cache four-phase handshake
//   mem_req/mem_we/mem_addr/mem_wdata : memory transaction outputs
//   ph0                           : tag 10=instr, 00=cache, 01=spacer
//   mem_done                      : asynchronous four-phase completion
//   busy                          : FSM not idle
//   timeout_err                   : sticky, set when a transaction times out
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              instr_ack,
  input  logic              cache_req,
  input  logic              cache_we,
  input  logic [ADDR_W-1:0] cache_addr,
  input  logic [DATA_W-1:0] cache_wdata,
  output logic              cache_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        ph0,
  input  logic              mem_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [TimeoutCntW-1:0] TimeoutCnt = TimeoutCntW'(TIMEOUT);

  logic req_i, req_c, done;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_instr (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (instr_req),
    .q    (req_i)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_cache (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cache_req),
    .q    (req_c)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_done (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (mem_done),
    .q    (done)
  );

  state_e                 state_q;
  grant_e                 grant_q, last_grant_q, win;
  logic [TimeoutCntW-1:0] cnt_q;
  logic                   mem_req_q, mem_we_q, instr_ack_q, cache_ack_q, timeout_err_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic [DATA_W-1:0]      mem_wdata_q;
  logic [1:0]             ph0_q;
  logic                   grant_req;

  // Round robin: on a tie the requester that did not win last time gets the port.
  always_comb begin
    win = GntInstr;
    if (req_i && req_c) begin
      win = (last_grant_q == GntCache) ? GntInstr : GntCache;
    end else if (req_c) begin
      win = GntCache;
    end
  end

  assign grant_req = (grant_q == GntInstr) ? req_i : req_c;

  // Outputs are loaded on the edge that enters ISSUE so mem_req is visible one
  // cycle after the synchronised request is seen in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      grant_q       <= GntInstr;
      last_grant_q  <= GntCache;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      ph0_q         <= PH0_IDLE;
      instr_ack_q   <= 1'b0;
      cache_ack_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_i || req_c) begin
            state_q      <= StIssue;
            grant_q      <= win;
            last_grant_q <= win;
            cnt_q        <= '0;
            mem_req_q    <= 1'b1;
            if (win == GntInstr) begin
              mem_addr_q  <= instr_addr;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
              ph0_q       <= PH0_INSTR;
            end else begin
              mem_addr_q  <= cache_addr;
              mem_we_q    <= cache_we;
              mem_wdata_q <= cache_wdata;
              ph0_q       <= PH0_CACHE;
            end
          end
        end
        StIssue: begin
          state_q <= StWaitData;
        end
        StWaitData: begin
          if (done || (cnt_q == TimeoutCnt)) begin
            // A timed-out requester is still acknowledged; its data is undefined.
            if (!done) begin
              timeout_err_q <= 1'b1;
            end
            state_q     <= StAck;
            instr_ack_q <= (grant_q == GntInstr);
            cache_ack_q <= (grant_q == GntCache);
          end else begin
            cnt_q <= cnt_q + TimeoutCntW'(1);
          end
        end
        StAck: begin
          state_q <= StWaitRelease;
        end
        StWaitRelease: begin
          if (!grant_req) begin
            instr_ack_q <= 1'b0;
            cache_ack_q <= 1'b0;
            mem_req_q   <= 1'b0;
            ph0_q       <= PH0_IDLE;
            state_q     <= StWaitRtz;
          end
        end
        StWaitRtz: begin
          if (!done) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign instr_ack   = instr_ack_q;
  assign cache_ack   = cache_ack_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign ph0         = ph0_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected memory
// transactions; a monitor pops one each time mem_req rises and checks tag/fields.
module tb_mem_port_arbiter;

  localparam int SYNC = 2;
  localparam int TMO  = 255;
  localparam int SelInstrAck = 0;
  localparam int SelCacheAck = 1;
  localparam int SelMemReq   = 2;

  typedef struct packed {
    logic [1:0]  ph0;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_req = 1'b0;
  logic [15:0] instr_addr = '0;
  logic        instr_ack;
  logic        cache_req = 1'b0;
  logic        cache_we = 1'b0;
  logic [15:0] cache_addr = '0;
  logic [15:0] cache_wdata = '0;
  logic        cache_ack;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [1:0]  ph0;
  logic        mem_done = 1'b0;
  logic        busy, timeout_err;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  bit   instr_auto = 1'b1;
  bit   cache_auto = 1'b1;
  bit   resp_en = 1'b1;
  int   done_delay = 5;

  mem_port_arbiter #(
    .ADDR_W     (16),
    .DATA_W     (16),
    .SYNC_STAGES(SYNC),
    .TIMEOUT    (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_req  (instr_req),
    .instr_addr (instr_addr),
    .instr_ack  (instr_ack),
    .cache_req  (cache_req),
    .cache_we   (cache_we),
    .cache_addr (cache_addr),
    .cache_wdata(cache_wdata),
    .cache_ack  (cache_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .ph0        (ph0),
    .mem_done   (mem_done),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] p, input logic w, input logic [15:0] a,
                              input logic [15:0] d);
    exp_t e;
    e.ph0 = p; e.we = w; e.addr = a; e.wdata = d;
    return e;
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      SelInstrAck: return instr_ack;
      SelCacheAck: return cache_ack;
      default:     return mem_req;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (sig(sel) === 1'b1) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // Counts rising clock edges until the selected output is seen high.
  task automatic measure(input int sel, input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (sig(sel) === 1'b1) break;
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit idle = 1'b0;
    for (int i = 0; i < budget && !idle; i++) begin
      @(negedge clk);
      if (!instr_req && !cache_req && !busy && !mem_req && !mem_done) idle = 1'b1;
    end
    check({name, "_idle"}, 32'(idle), 32'd1);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Requesters drop req as soon as their ack is seen (four-phase).
  initial forever begin
    @(negedge clk);
    if (instr_auto && instr_req && instr_ack) instr_req = 1'b0;
    if (cache_auto && cache_req && cache_ack) cache_req = 1'b0;
  end

  // Memory side: return done some cycles into a transaction, drop it once mem_req falls.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!mem_req) begin
        mem_done = 1'b0;
        cnt = 0;
      end else if (resp_en && !mem_done) begin
        cnt++;
        if (cnt >= done_delay) mem_done = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic       prev_req;
    logic [1:0] prev_ph0;
    exp_t       cur;
    bit         have_cur;
    prev_req = 1'b0;
    prev_ph0 = 2'b01;
    have_cur = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
        prev_ph0 = ph0;
        continue;
      end
      check("ack_exclusive", 32'(instr_ack && cache_ack), 32'd0);
      check("ack_without_req", 32'((instr_ack || cache_ack) && !mem_req), 32'd0);
      if (mem_req && !prev_req) begin
        check("spacer_before_txn", 32'(prev_ph0), 32'(2'b01));
        if (exp_q.size() == 0) begin
          check("unexpected_txn", 32'd1, 32'd0);
          have_cur = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          check("txn_ph0", 32'(ph0), 32'(cur.ph0));
          check("txn_we", 32'(mem_we), 32'(cur.we));
          check("txn_addr", 32'(mem_addr), 32'(cur.addr));
          check("txn_wdata", 32'(mem_wdata), 32'(cur.wdata));
        end
      end else if (mem_req && have_cur) begin
        check("ph0_stable", 32'(ph0), 32'(cur.ph0));
        check("ack_owner", 32'((cur.ph0 == 2'b10) ? cache_ack : instr_ack), 32'd0);
      end
      prev_req = mem_req;
      prev_ph0 = ph0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ph0", 32'(ph0), 32'(2'b01));
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_acks", 32'({instr_ack, cache_ack}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single instruction fetch; mem_req rises SYNC+1 edges after the raw request.
    exp_q.push_back(mk(2'b10, 1'b0, 16'h1234, 16'h0000));
    instr_addr = 16'h1234;
    instr_req  = 1'b1;
    measure(SelMemReq, 20, n);
    check("instr_req_latency", 32'(n), 32'(SYNC + 1));
    wait_idle(100, "instr1");
    check("instr1_ph0_spacer", 32'(ph0), 32'(2'b01));

    // Cache write.
    exp_q.push_back(mk(2'b00, 1'b1, 16'h00F0, 16'hBEEF));
    cache_addr  = 16'h00F0;
    cache_wdata = 16'hBEEF;
    cache_we    = 1'b1;
    cache_req   = 1'b1;
    wait_idle(100, "cache_wr");

    // Two rounds of simultaneous requests: instr, cache, instr, cache.
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      instr_addr  = (r == 0) ? 16'h1111 : 16'h3333;
      cache_addr  = (r == 0) ? 16'h2222 : 16'h4444;
      cache_we    = (r == 1);
      cache_wdata = (r == 0) ? 16'h7777 : 16'h5A5A;
      exp_q.push_back(mk(2'b10, 1'b0, instr_addr, 16'h0000));
      exp_q.push_back(mk(2'b00, cache_we, cache_addr, cache_wdata));
      instr_req = 1'b1;
      cache_req = 1'b1;
      wait_idle(200, "both");
    end
    check("no_timeout_yet", 32'(timeout_err), 32'd0);

    // Timeout: ack arrives after the ISSUE cycle plus TMO+1 counting cycles.
    resp_en = 1'b0;
    exp_q.push_back(mk(2'b10, 1'b0, 16'hABCD, 16'h0000));
    instr_addr = 16'hABCD;
    instr_req  = 1'b1;
    measure(SelMemReq, 20, n);
    check("tmo_req_latency", 32'(n), 32'(SYNC + 1));
    measure(SelInstrAck, 400, n);
    check("tmo_ack_cycles", 32'(n), 32'(TMO + 2));
    check("tmo_err_set", 32'(timeout_err), 32'd1);
    check("tmo_no_done", 32'(mem_done), 32'd0);
    wait_idle(100, "tmo");
    resp_en = 1'b1;
    exp_q.push_back(mk(2'b00, 1'b0, 16'h5555, 16'h0000));
    cache_addr  = 16'h5555;
    cache_we    = 1'b0;
    cache_wdata = 16'h0000;
    cache_req   = 1'b1;
    wait_idle(100, "after_tmo");
    check("tmo_err_sticky", 32'(timeout_err), 32'd1);

    // Cache holds req for 10 cycles after its ack; a pending fetch must wait.
    cache_auto = 1'b0;
    exp_q.push_back(mk(2'b00, 1'b1, 16'h0E0E, 16'h1357));
    exp_q.push_back(mk(2'b10, 1'b0, 16'h0F0F, 16'h0000));
    cache_addr  = 16'h0E0E;
    cache_wdata = 16'h1357;
    cache_we    = 1'b1;
    cache_req   = 1'b1;
    wait_for(SelCacheAck, 50, "hold_ack_seen");
    instr_addr = 16'h0F0F;
    instr_req  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_mem_req", 32'(mem_req), 32'd1);
      check("hold_ph0", 32'(ph0), 32'(2'b00));
      check("hold_cache_ack", 32'(cache_ack), 32'd1);
    end
    cache_req  = 1'b0;
    cache_auto = 1'b1;
    wait_idle(150, "hold");

    // Reset in WAIT_RELEASE, instr dropped during reset: pending cache is served.
    instr_auto = 1'b0;
    exp_q.push_back(mk(2'b10, 1'b0, 16'h0202, 16'h0000));
    instr_addr = 16'h0202;
    instr_req  = 1'b1;
    wait_for(SelInstrAck, 50, "rstA_ack_seen");
    cache_addr  = 16'h0D0D;
    cache_we    = 1'b1;
    cache_wdata = 16'h2468;
    cache_req   = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstA_mem_req", 32'(mem_req), 32'd0);
    check("rstA_acks", 32'({instr_ack, cache_ack}), 32'd0);
    check("rstA_ph0", 32'(ph0), 32'(2'b01));
    instr_req = 1'b0;
    exp_q.push_back(mk(2'b00, 1'b1, 16'h0D0D, 16'h2468));
    @(negedge clk);
    rst_n = 1'b1;
    instr_auto = 1'b1;
    wait_idle(150, "rstA");

    // Reset in WAIT_RELEASE, instr still high: instr wins over the pending cache.
    instr_auto = 1'b0;
    exp_q.push_back(mk(2'b10, 1'b0, 16'h0101, 16'h0000));
    instr_addr = 16'h0101;
    instr_req  = 1'b1;
    wait_for(SelInstrAck, 50, "rstB_ack_seen");
    cache_addr  = 16'h0C0C;
    cache_we    = 1'b0;
    cache_wdata = 16'h0000;
    cache_req   = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstB_mem_req", 32'(mem_req), 32'd0);
    check("rstB_acks", 32'({instr_ack, cache_ack}), 32'd0);
    check("rstB_ph0", 32'(ph0), 32'(2'b01));
    check("rstB_tmo_cleared", 32'(timeout_err), 32'd0);
    exp_q.push_back(mk(2'b10, 1'b0, 16'h0101, 16'h0000));
    exp_q.push_back(mk(2'b00, 1'b0, 16'h0C0C, 16'h0000));
    @(negedge clk);
    rst_n = 1'b1;
    wait_for(SelInstrAck, 60, "rstB_reserve_ack");
    instr_req  = 1'b0;
    instr_auto = 1'b1;
    wait_idle(150, "rstB");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
